// File: rtl/pwm_pkg.sv
// Shared types, constants and helpers for the PWM ramp sequencer.
package pwm_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned FREQ_W = 8;

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [FREQ_W-1:0] freq_t;

  localparam duty_t PWM_DUTY_MAX = duty_t'(100);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RAMP = 2'd2
  } pwm_state_e;

  // Latched command payload
  typedef struct packed {
    duty_t duty;
    freq_t freq;
    logic  ramp;
  } pwm_cmd_t;

  function automatic duty_t clamp_duty(input duty_t d);
    return (d > PWM_DUTY_MAX) ? PWM_DUTY_MAX : d;
  endfunction

endpackage

// File: rtl/pwm_period_tracker.sv
// Tracks the position inside the current PWM period and flags its last cycle.
module pwm_period_tracker
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] freq,
  input  logic       load,
  output logic       period_end
);

  freq_t count_q;
  logic  wrap_c;

  // freq == 0 means the channel is off: every cycle is a boundary
  assign wrap_c     = (freq == '0) || (count_q == (freq - freq_t'(1)));
  assign period_end = rst_n && wrap_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load || wrap_c) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + freq_t'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Command-driven duty/freq sequencer for one PWM channel; updates land on period boundaries.
// Optional abort support is enabled by defining PWM_SEQ_ABORT_EN.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned RAMP_STEP    = 1,
  parameter int unsigned HOLD_PERIODS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic [7:0] cmd_freq,
  input  logic       cmd_ramp,
  output logic [7:0] duty_cycle,
  output logic [7:0] freq,
  output logic       period_end,
  output logic       busy,
  output logic       done
`ifdef PWM_SEQ_ABORT_EN
  ,
  input  logic       cmd_abort,
  output logic       aborted
`endif
);

  localparam int unsigned EXT_W   = 9;
  localparam int unsigned HOLD_W  = 8;
  localparam logic [EXT_W-1:0]  STEP_EXT = EXT_W'(RAMP_STEP);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLD_PERIODS);

  pwm_state_e         state_q, state_d;
  pwm_cmd_t           tgt_q, tgt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  duty_t              duty_d;
  freq_t              freq_d;
  logic               done_d;
  logic               freq_load_c;

  logic [EXT_W-1:0]   duty_ext_c, tgt_ext_c, up_c, dn_c;
  duty_t              step_c;

`ifdef PWM_SEQ_ABORT_EN
  logic               aborted_d;
`endif

  pwm_period_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .freq       (freq),
    .load       (freq_load_c),
    .period_end (period_end)
  );

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = rst_n && (state_q == ST_IDLE);

  // One ramp step toward the target, saturating at the target in either direction
  assign duty_ext_c = {1'b0, duty_cycle};
  assign tgt_ext_c  = {1'b0, tgt_q.duty};
  assign up_c       = duty_ext_c + STEP_EXT;
  assign dn_c       = duty_ext_c - STEP_EXT;

  always_comb begin
    step_c = tgt_q.duty;
    if (tgt_ext_c > duty_ext_c) begin
      step_c = (up_c >= tgt_ext_c) ? tgt_q.duty : up_c[7:0];
    end else begin
      step_c = (dn_c[8] || (dn_c[7:0] <= tgt_q.duty)) ? tgt_q.duty : dn_c[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    hold_d      = hold_q;
    duty_d      = duty_cycle;
    freq_d      = freq;
    done_d      = 1'b0;
    freq_load_c = 1'b0;
`ifdef PWM_SEQ_ABORT_EN
    aborted_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tgt_d.duty = clamp_duty(cmd_duty);
          tgt_d.freq = cmd_freq;
          tgt_d.ramp = cmd_ramp;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (period_end) begin
          freq_d      = tgt_q.freq;
          freq_load_c = 1'b1;
          if (!tgt_q.ramp || (duty_cycle == tgt_q.duty)) begin
            duty_d  = tgt_q.duty;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hold_d  = HOLD_LD;
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (period_end) begin
          if (hold_q == HOLD_W'(1)) begin
            duty_d = step_c;
            hold_d = HOLD_LD;
            if (step_c == tgt_q.duty) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PWM_SEQ_ABORT_EN
    // Abort wins over a coincident boundary; outputs stay frozen
    if (cmd_abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      hold_d      = hold_q;
      duty_d      = duty_cycle;
      freq_d      = freq;
      done_d      = 1'b0;
      freq_load_c = 1'b0;
      aborted_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      hold_q     <= '0;
      duty_cycle <= '0;
      freq       <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      hold_q     <= hold_d;
      duty_cycle <= duty_d;
      freq       <= freq_d;
      done       <= done_d;
    end
  end

`ifdef PWM_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else begin
      aborted <= aborted_d;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed table, hand sequences and random traffic
// checked every cycle against a plan-based reference model.
module tb_pwm_ramp_sequencer;

  localparam int RSTEP = 10;
  localparam int RHOLD = 2;
  localparam int LAT_BOUND = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_duty;
  logic [7:0] cmd_freq;
  logic       cmd_ramp;
  logic [7:0] duty_cycle;
  logic [7:0] freq;
  logic       period_end;
  logic       busy;
  logic       done;
`ifdef PWM_SEQ_ABORT_EN
  logic       cmd_abort;
  logic       aborted;
`endif

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .RAMP_STEP    (RSTEP),
    .HOLD_PERIODS (RHOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_duty   (cmd_duty),
    .cmd_freq   (cmd_freq),
    .cmd_ramp   (cmd_ramp),
    .duty_cycle (duty_cycle),
    .freq       (freq),
    .period_end (period_end),
    .busy       (busy),
    .done       (done)
`ifdef PWM_SEQ_ABORT_EN
    ,
    .cmd_abort  (cmd_abort),
    .aborted    (aborted)
`endif
  );

  int n_cmp;
  int n_err;

  // Reference model: applied values, period position and the list of duty values still to apply
  int m_duty, m_freq, m_count, m_hold;
  int t_duty, t_freq;
  bit t_ramp, m_busy, m_done, m_armed;
  int plan[$];
`ifdef PWM_SEQ_ABORT_EN
  bit m_aborted;
`endif

  typedef struct {
    int duty;
    int freq;
    int ramp;
    int exp_duty;
    int exp_freq;
    int exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_freq = 0; m_count = 0; m_hold = 0;
    m_busy = 0; m_done = 0; m_armed = 0;
    t_duty = 0; t_freq = 0; t_ramp = 0;
    plan.delete();
`ifdef PWM_SEQ_ABORT_EN
    m_aborted = 0;
`endif
  endtask

  task automatic compare_outputs();
    bit pe_m;
    pe_m = rst_n && ((m_freq == 0) || (m_count == m_freq - 1));
    check("duty_cycle", 16'(duty_cycle), 16'(m_duty));
    check("freq", 16'(freq), 16'(m_freq));
    check("period_end", 16'(period_end), 16'(pe_m));
    check("busy", 16'(busy), 16'(m_busy));
    check("done", 16'(done), 16'(m_done));
    check("cmd_ready", 16'(cmd_ready), 16'(rst_n && !m_busy));
`ifdef PWM_SEQ_ABORT_EN
    check("aborted", 16'(aborted), 16'(m_aborted));
`endif
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_step();
    bit pe;
    int next_count;
    int v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pe = (m_freq == 0) || (m_count == m_freq - 1);
    next_count = pe ? 0 : m_count + 1;
    m_done = 0;
`ifdef PWM_SEQ_ABORT_EN
    m_aborted = 0;
    if (cmd_abort && m_busy) begin
      m_busy = 0;
      m_armed = 0;
      m_aborted = 1;
      plan.delete();
      m_count = next_count;
      return;
    end
`endif
    if (!m_busy) begin
      if (cmd_valid) begin
        t_duty = (int'(cmd_duty) > 100) ? 100 : int'(cmd_duty);
        t_freq = int'(cmd_freq);
        t_ramp = cmd_ramp;
        m_busy = 1;
        m_armed = 1;
      end
    end else if (pe) begin
      if (m_armed) begin
        m_armed = 0;
        m_freq = t_freq;
        next_count = 0;
        if (!t_ramp || m_duty == t_duty) begin
          m_duty = t_duty;
          m_done = 1;
          m_busy = 0;
        end else begin
          plan.delete();
          v = m_duty;
          while (v != t_duty) begin
            if (t_duty > v) v = (v + RSTEP >= t_duty) ? t_duty : v + RSTEP;
            else            v = (v - RSTEP <= t_duty) ? t_duty : v - RSTEP;
            plan.push_back(v);
          end
          m_hold = RHOLD;
        end
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          m_duty = plan.pop_front();
          m_hold = RHOLD;
          if (plan.size() == 0) begin
            m_done = 1;
            m_busy = 0;
          end
        end
      end
    end
    m_count = next_count;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and count cycles until done is seen
  task automatic run_cmd(input int d, input int f, input int r, output int lat);
    cmd_valid = 1'b1;
    cmd_duty  = 8'(d);
    cmd_freq  = 8'(f);
    cmd_ramp  = r[0];
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LAT_BOUND) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_err = 0;

    // duty, freq, ramp, expected duty, expected freq, cycles from request to done
    vecs[0] = '{50,  20, 0,  50, 20,   2};
    vecs[1] = '{30,  10, 0,  30, 10,  20};
    vecs[2] = '{200, 10, 0, 100, 10,  10};
    vecs[3] = '{7,   10, 1,   7, 10, 210};
    vecs[4] = '{0,    4, 1,   0,  4,  18};
    vecs[5] = '{100,  4, 1, 100,  4,  84};
    vecs[6] = '{100,  4, 1, 100,  4,   4};
    vecs[7] = '{40,   0, 0,  40,  0,   4};
    vecs[8] = '{60,   0, 1,  60,  0,   6};
    vecs[9] = '{0,    1, 0,   0,  1,   2};

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_duty = 8'd77; cmd_freq = 8'd9; cmd_ramp = 1'b0;
`ifdef PWM_SEQ_ABORT_EN
    cmd_abort = 1'b0;
`endif
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) tick();
    check("reset_ready", 16'(cmd_ready), 16'd0);
    check("reset_duty", 16'(duty_cycle), 16'd0);
    check("reset_pe", 16'(period_end), 16'd0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("release_ready", 16'(cmd_ready), 16'd1);
    tick();

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].duty, vecs[i].freq, vecs[i].ramp, lat);
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'(vecs[i].exp_lat));
      check($sformatf("vec%0d_duty", i), 16'(duty_cycle), 16'(vecs[i].exp_duty));
      check($sformatf("vec%0d_freq", i), 16'(freq), 16'(vecs[i].exp_freq));
    end

    // Boundary alignment: request lands mid-period at count 3 of a 10-clock period
    run_cmd(20, 10, 0, lat);
    check("align_setup_lat", 16'(lat), 16'd2);
    for (int i = 0; i < 3; i++) tick();
    cmd_valid = 1'b1; cmd_duty = 8'd30; cmd_freq = 8'd10; cmd_ramp = 1'b0;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LAT_BOUND) begin
      check("align_hold_duty", 16'(duty_cycle), 16'd20);
      tick();
      lat++;
    end
    check("align_latency", 16'(lat), 16'd7);
    check("align_duty", 16'(duty_cycle), 16'd30);

    // Reset in the middle of a ramp aborts it without done
    cmd_valid = 1'b1; cmd_duty = 8'd100; cmd_freq = 8'd4; cmd_ramp = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_busy", 16'(busy), 16'd0);
    check("midreset_done", 16'(done), 16'd0);
    check("midreset_duty", 16'(duty_cycle), 16'd0);
    for (int i = 0; i < 20; i++) tick();

`ifdef PWM_SEQ_ABORT_EN
    // Abort a ramp when duty reaches 50
    cmd_valid = 1'b1; cmd_duty = 8'd100; cmd_freq = 8'd4; cmd_ramp = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (duty_cycle != 8'd50 && lat < LAT_BOUND) begin
      tick();
      lat++;
    end
    check("abort_reach50", 16'(duty_cycle), 16'd50);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_pulse", 16'(aborted), 16'd1);
    check("abort_duty", 16'(duty_cycle), 16'd50);
    check("abort_ready", 16'(cmd_ready), 16'd1);
    check("abort_no_done", 16'(done), 16'd0);
    for (int i = 0; i < 40; i++) tick();
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_duty  = 8'($urandom_range(0, 255));
      cmd_freq  = 8'($urandom_range(0, 8));
      cmd_ramp  = 1'($urandom_range(0, 1));
`ifdef PWM_SEQ_ABORT_EN
      cmd_abort = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end

    rst_n = 1'b1;
    cmd_valid = 1'b0;
`ifdef PWM_SEQ_ABORT_EN
    cmd_abort = 1'b0;
`endif
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
